pipeline_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage core. Drives the stop and bubble inputs of the EX stage
//  and the hold/flush/PC-load controls of IF/ID, from load-use hazards, EX redirects (wb_pc), MEM waits
//  and external halt. Sits beside the pipeline; owns no datapath except the redirect PC mux-through.

---
 rtl/kasumi_ctrl_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/kasumi_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// Covers the FSM state encoding and the layout of the EX memory-command field.
package kasumi_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_FLUSH    = 3'd1,
      ST_MEM_WAIT = 3'd2,
      ST_HALT     = 3'd3
   } ctrl_state_e;

   localparam int MEMCMD_ACCESS_BIT = 0;
   localparam int MEMCMD_WRITE_BIT  = 1;

   localparam logic [4:0] MEM_ACCESS = 5'b00001;
   localparam logic [4:0] MEM_WRITE  = 5'b00010;

   // A load is an access that is not a write; funct3 does not matter for hazards.
   function automatic logic is_load(input logic [4:0] cmd);
      return cmd[MEMCMD_ACCESS_BIT] && !cmd[MEMCMD_WRITE_BIT];
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags an ID source that matches the rd of a load in EX.
// Zero latency, no state, no flow control.
module hazard_detect
   import kasumi_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_use_rs1_i,
   input  logic       id_use_rs2_i,
   input  logic [4:0] ex_reg_d_i,
   input  logic [1:0] ex_mem_kind_i,
   output logic       load_use_o
);

   logic ex_is_load;
   logic rs1_hit;
   logic rs2_hit;

   assign ex_is_load = is_load({3'b000, ex_mem_kind_i});
   assign rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_reg_d_i);
   assign rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_reg_d_i);

   // x0 is hardwired zero, so a load into it never creates a dependency.
   assign load_use_o = ex_is_load && (ex_reg_d_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stop/hold/flush/bubble/PC-load for a 5-stage core, Mealy outputs.
// Optional perf counters when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
   import kasumi_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int XLEN         = 32
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            halt_req,
   input  logic            mem_busy,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   input  logic [4:0]      ex_reg_d,
   input  logic [4:0]      ex_mem_command,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            stop,
   output logic            hold_front,
   output logic            flush_front,
   output logic            bubble_ex,
   output logic            pc_load,
   output logic [XLEN-1:0] pc_load_data,
   output logic [2:0]      ctrl_state
`ifdef PIPELINE_CTRL_PERF_EN
   ,
   output logic [31:0]     perf_stall_cyc,
   output logic [31:0]     perf_flush_cyc
`endif
);

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   ctrl_state_e state_q, state_d;
   ctrl_state_e resume_q, resume_d;
   ctrl_state_e eff_state;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic        load_use;
   logic        freeze;
   logic        unused_funct3;

   assign unused_funct3 = ^ex_mem_command[4:2];
   assign freeze        = mem_busy || halt_req;

   hazard_detect u_hazard_detect (
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_use_rs1_i  (id_use_rs1),
      .id_use_rs2_i  (id_use_rs2),
      .ex_reg_d_i    (ex_reg_d),
      .ex_mem_kind_i (ex_mem_command[1:0]),
      .load_use_o    (load_use)
   );

   // On the release cycle of a freeze the controller already acts as the saved
   // state, so no unflushed cycle slips through between the stall and the resume.
   always_comb begin
      eff_state = state_q;
      if (state_q == ST_MEM_WAIT || state_q == ST_HALT) begin
         eff_state = resume_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         resume_q    <= ST_RUN;
         flush_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         resume_q    <= resume_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      resume_d    = resume_q;
      flush_cnt_d = flush_cnt_q;
      if (freeze) begin
         state_d = mem_busy ? ST_MEM_WAIT : ST_HALT;
         if (state_q == ST_RUN || state_q == ST_FLUSH) begin
            resume_d = state_q;
         end
      end else begin
         case (eff_state)
            ST_FLUSH: begin
               flush_cnt_d = flush_cnt_q - 3'd1;
               state_d     = (flush_cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
            end
            default: begin
               state_d = ST_RUN;
               if (redirect && FLUSH_CYCLES > 1) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FLUSH_INIT;
               end
            end
         endcase
      end
   end

   always_comb begin
      stop         = 1'b0;
      hold_front   = 1'b0;
      flush_front  = 1'b0;
      bubble_ex    = 1'b0;
      pc_load      = 1'b0;
      pc_load_data = '0;
      if (!reset) begin
         stop = 1'b0;
      end else if (freeze) begin
         stop = 1'b1;
      end else begin
         case (eff_state)
            ST_FLUSH: begin
               flush_front = 1'b1;
               bubble_ex   = 1'b1;
            end
            default: begin
               if (redirect) begin
                  pc_load      = 1'b1;
                  pc_load_data = redirect_pc;
                  flush_front  = 1'b1;
                  bubble_ex    = 1'b1;
               end else if (load_use) begin
                  hold_front = 1'b1;
                  bubble_ex  = 1'b1;
               end
            end
         endcase
      end
   end

   assign ctrl_state = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_q <= 32'd0;
         perf_flush_q <= 32'd0;
      end else begin
         perf_stall_q <= perf_stall_q + {31'd0, (stop | hold_front)};
         perf_flush_q <= perf_flush_q + {31'd0, flush_front};
      end
   end

   assign perf_stall_cyc = perf_stall_q;
   assign perf_flush_cyc = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected outputs queued per step, compared at negedge.
module tb_pipeline_ctrl;

   localparam logic [2:0] RUN = 3'd0, FLS = 3'd1, MW = 3'd2, HLT = 3'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt_req, mem_busy, id_use_rs1, id_use_rs2, redirect;
   logic [4:0]  id_rs1, id_rs2, ex_reg_d, ex_mem_command;
   logic [31:0] redirect_pc;
   logic        stop, hold_front, flush_front, bubble_ex, pc_load;
   logic [31:0] pc_load_data;
   logic [2:0]  ctrl_state;
`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] perf_stall_cyc, perf_flush_cyc;
`endif

   typedef struct packed {
      logic        stp;
      logic        hld;
      logic        fls;
      logic        bub;
      logic        pcl;
      logic [31:0] pcd;
      logic [2:0]  st;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad   = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .halt_req       (halt_req),
      .mem_busy       (mem_busy),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_use_rs1     (id_use_rs1),
      .id_use_rs2     (id_use_rs2),
      .ex_reg_d       (ex_reg_d),
      .ex_mem_command (ex_mem_command),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .stop           (stop),
      .hold_front     (hold_front),
      .flush_front    (flush_front),
      .bubble_ex      (bubble_ex),
      .pc_load        (pc_load),
      .pc_load_data   (pc_load_data),
      .ctrl_state     (ctrl_state)
`ifdef PIPELINE_CTRL_PERF_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cyc (perf_flush_cyc)
`endif
   );

   task automatic idle();
      halt_req       = 1'b0;
      mem_busy       = 1'b0;
      id_rs1         = 5'd0;
      id_rs2         = 5'd0;
      id_use_rs1     = 1'b0;
      id_use_rs2     = 1'b0;
      ex_reg_d       = 5'd0;
      ex_mem_command = 5'd0;
      redirect       = 1'b0;
      redirect_pc    = 32'd0;
   endtask

   task automatic load_use_in(input logic [4:0] rd);
      ex_mem_command = 5'b00001;
      ex_reg_d       = rd;
      id_rs1         = rd;
      id_use_rs1     = 1'b1;
   endtask

   task automatic check_one();
      exp_t  e;
      exp_t  o;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {stop, hold_front, flush_front, bubble_ex, pc_load, pc_load_data, ctrl_state};
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed stp/hld/fls/bub/pcl=%b%b%b%b%b pcd=%h st=%0d expected %b%b%b%b%b pcd=%h st=%0d",
                t, o.stp, o.hld, o.fls, o.bub, o.pcl, o.pcd, o.st,
                e.stp, e.hld, e.fls, e.bub, e.pcl, e.pcd, e.st);
      end
   endtask

   // Inputs are already driven for this cycle; push expectation, compare at negedge, step.
   task automatic expect_out(input string tag, input logic s, input logic h, input logic f,
                             input logic b, input logic p, input logic [31:0] d,
                             input logic [2:0] st);
      exp_t e;
      e = {s, h, f, b, p, d, st};
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      check_one();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset       = 1'b0;
      halt_req    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h55;
      expect_out("reset", 0, 0, 0, 0, 0, 32'h0, RUN);

      reset = 1'b1;
      idle();
      expect_out("idle", 0, 0, 0, 0, 0, 32'h0, RUN);

      load_use_in(5'd5);
      expect_out("lu_rs1", 0, 1, 0, 1, 0, 32'h0, RUN);
      ex_mem_command = 5'b00000;
      expect_out("lu_after", 0, 0, 0, 0, 0, 32'h0, RUN);

      idle();
      ex_mem_command = 5'b01001;
      ex_reg_d = 5'd7; id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
      expect_out("lu_rs2", 0, 1, 0, 1, 0, 32'h0, RUN);

      idle();
      ex_mem_command = 5'b00001;
      ex_reg_d = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7;
      expect_out("no_use", 0, 0, 0, 0, 0, 32'h0, RUN);

      idle();
      ex_mem_command = 5'b00011;
      ex_reg_d = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
      expect_out("store", 0, 0, 0, 0, 0, 32'h0, RUN);

      idle();
      load_use_in(5'd0);
      expect_out("lu_x0", 0, 0, 0, 0, 0, 32'h0, RUN);

      idle();
      load_use_in(5'd5);
      redirect = 1'b1; redirect_pc = 32'h100;
      expect_out("redir_lu", 0, 0, 1, 1, 1, 32'h100, RUN);
      redirect_pc = 32'h200;
      expect_out("flush2", 0, 0, 1, 1, 0, 32'h0, FLS);
      idle();
      expect_out("back_run", 0, 0, 0, 0, 0, 32'h0, RUN);

      redirect = 1'b1; redirect_pc = 32'h100;
      expect_out("redir2", 0, 0, 1, 1, 1, 32'h100, RUN);
      idle();
      mem_busy = 1'b1;
      expect_out("mb1", 1, 0, 0, 0, 0, 32'h0, FLS);
      expect_out("mb2", 1, 0, 0, 0, 0, 32'h0, MW);
      expect_out("mb3", 1, 0, 0, 0, 0, 32'h0, MW);
      mem_busy = 1'b0;
      expect_out("mb_rel", 0, 0, 1, 1, 0, 32'h0, MW);
      expect_out("run4", 0, 0, 0, 0, 0, 32'h0, RUN);

      redirect = 1'b1; redirect_pc = 32'h40;
      expect_out("redir3", 0, 0, 1, 1, 1, 32'h40, RUN);
      idle();
      mem_busy = 1'b1;
      expect_out("fl_mb", 1, 0, 0, 0, 0, 32'h0, FLS);
      mem_busy = 1'b0; halt_req = 1'b1;
      expect_out("mw_halt", 1, 0, 0, 0, 0, 32'h0, MW);
      halt_req = 1'b0;
      expect_out("halt_rel", 0, 0, 1, 1, 0, 32'h0, HLT);
      expect_out("run5", 0, 0, 0, 0, 0, 32'h0, RUN);

      halt_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
      expect_out("halt_redir", 1, 0, 0, 0, 0, 32'h0, RUN);
      redirect = 1'b0; redirect_pc = 32'h0;
      expect_out("halt_hold", 1, 0, 0, 0, 0, 32'h0, HLT);
      reset = 1'b0;
      expect_out("halt_rst", 0, 0, 0, 0, 0, 32'h0, RUN);

      reset = 1'b1;
      idle();
      expect_out("post_rst", 0, 0, 0, 0, 0, 32'h0, RUN);

      mem_busy = 1'b1;
      expect_out("pmb1", 1, 0, 0, 0, 0, 32'h0, RUN);
      expect_out("pmb2", 1, 0, 0, 0, 0, 32'h0, MW);
      expect_out("pmb3", 1, 0, 0, 0, 0, 32'h0, MW);
      expect_out("pmb4", 1, 0, 0, 0, 0, 32'h0, MW);
      idle();
      load_use_in(5'd9);
      expect_out("plu", 0, 1, 0, 1, 0, 32'h0, MW);
      idle();
      expect_out("pidle", 0, 0, 0, 0, 0, 32'h0, RUN);

`ifdef PIPELINE_CTRL_PERF_EN
      total++;
      assert (perf_stall_cyc === 32'd5) else begin
         bad++;
         $error("FAIL perf_stall observed=%0d expected=5", perf_stall_cyc);
      end
      total++;
      assert (perf_flush_cyc === 32'd0) else begin
         bad++;
         $error("FAIL perf_flush observed=%0d expected=0", perf_flush_cyc);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
